// File: rtl/neuron_accum.sv
// Accumulate NBEATS unsigned partial sums with saturation, then compare
// the total against a threshold latched on the first beat.
module neuron_accum #(
   parameter int NBEATS = 4,
   parameter int ACC_W  = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_sum,
   input  logic [ACC_W-1:0] threshold,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_fire,
   output logic             out_sat,
   output logic             busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [ACC_W-1:0] ACC_MAX = '1;
   localparam logic [4:0]       LAST    = 5'(NBEATS);

   logic [1:0]       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] thr_q, thr_d;
   logic [4:0]       cnt_q, cnt_d;
   logic             sat_q, sat_d;

   logic             beat;
   logic [ACC_W:0]   sum_w;
   logic [4:0]       cnt_inc;

   assign in_ready = (state_q != S_DONE);
   assign beat     = in_valid & in_ready;
   assign sum_w    = {1'b0, acc_q} + (ACC_W+1)'(in_sum);
   assign cnt_inc  = cnt_q + 5'd1;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      thr_d   = thr_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      if (flush) begin
         state_d = S_IDLE;
         acc_d   = '0;
         thr_d   = '0;
         cnt_d   = '0;
         sat_d   = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (beat) begin
                  acc_d   = ACC_W'(in_sum);
                  thr_d   = threshold;
                  cnt_d   = 5'd1;
                  sat_d   = 1'b0;
                  state_d = (NBEATS == 1) ? S_DONE : S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (beat) begin
                  // carry out of the widened sum means the add overflowed
                  if (sum_w[ACC_W]) begin
                     acc_d = ACC_MAX;
                     sat_d = 1'b1;
                  end else begin
                     acc_d = sum_w[ACC_W-1:0];
                  end
                  cnt_d = cnt_inc;
                  if (cnt_inc == LAST) state_d = S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_d = S_IDLE;
                  acc_d   = '0;
                  cnt_d   = '0;
                  sat_d   = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         thr_q   <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         thr_q   <= thr_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

   assign out_valid = (state_q == S_DONE);
   assign out_acc   = out_valid ? acc_q : '0;
   assign out_fire  = out_valid & (acc_q >= thr_q);
   assign out_sat   = out_valid & sat_q;
   assign busy      = (state_q != S_IDLE);

endmodule
